host_descriptor_arbiter: RTL

Weighted round-robin arbiter that shares the single host descriptor FIFO (23-bit wide, 16 deep) between two requesters: the HCP port and the network port. Each requester presents a 48-bit TSN tag and a 9-bit buffer ID under a wr/ack handshake. The block packs one 23-bit descriptor per grant and writes it to the FIFO. It applies almost-full backpressure and keeps per-source grant counters for host-side status.

---
 rtl/host_descriptor_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/host_descriptor_arbiter.sv
// Weighted round-robin arbiter sharing the host descriptor FIFO between the
// HCP and network requesters; packs {tag[47:34], bufid} into 23-bit words.
module host_descriptor_arbiter #(
  parameter int unsigned HCP_WEIGHT   = 1,
  parameter int unsigned NET_WEIGHT   = 4,
  parameter int unsigned AF_THRESHOLD = 14
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [47:0] iv_tsntag_hcp,
  input  logic [8:0]  iv_bufid_hcp,
  input  logic        i_descriptor_wr_hcp,
  output logic        o_descriptor_ack_hcp,
  input  logic [47:0] iv_tsntag_network,
  input  logic [8:0]  iv_bufid_network,
  input  logic        i_descriptor_wr_network,
  output logic        o_descriptor_ack_network,
  output logic [22:0] ov_fifo_wdata,
  output logic        o_fifo_wr,
  input  logic [4:0]  iv_fifo_usedw,
  output logic [15:0] ov_hcp_grant_cnt,
  output logic [15:0] ov_net_grant_cnt
);

  localparam logic [3:0] HCP_W  = 4'(HCP_WEIGHT);
  localparam logic [3:0] NET_W  = 4'(NET_WEIGHT);
  localparam logic [4:0] AF_LVL = 5'(AF_THRESHOLD);

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef enum logic {SIDE_NET, SIDE_HCP} side_t;

  state_t      state_q;
  side_t       side_q;
  logic [3:0]  run_q;
  logic        fifo_wr_q;
  logic        ack_hcp_q;
  logic        ack_net_q;
  logic [22:0] wdata_q;
  logic [15:0] hcp_cnt_q;
  logic [15:0] net_cnt_q;

  side_t       grant_d;
  logic [3:0]  run_d;
  logic [3:0]  weight_cur;
  logic        req_any;
  logic        room;

  // Low tag bits are intentionally discarded from the descriptor.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{iv_tsntag_hcp[33:0], iv_tsntag_network[33:0]};

  always_comb begin
    req_any    = i_descriptor_wr_hcp | i_descriptor_wr_network;
    room       = iv_fifo_usedw < AF_LVL;
    weight_cur = (side_q == SIDE_HCP) ? HCP_W : NET_W;
    grant_d    = SIDE_NET;
    if (i_descriptor_wr_hcp && i_descriptor_wr_network) begin
      if (run_q < weight_cur) grant_d = side_q;
      else                    grant_d = (side_q == SIDE_HCP) ? SIDE_NET : SIDE_HCP;
    end else if (i_descriptor_wr_hcp) begin
      grant_d = SIDE_HCP;
    end
    if (grant_d == side_q) run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
    else                   run_d = 4'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      side_q    <= SIDE_NET;
      run_q     <= '0;
      fifo_wr_q <= 1'b0;
      ack_hcp_q <= 1'b0;
      ack_net_q <= 1'b0;
      wdata_q   <= '0;
      hcp_cnt_q <= '0;
      net_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          fifo_wr_q <= 1'b0;
          ack_hcp_q <= 1'b0;
          ack_net_q <= 1'b0;
          if (room && req_any) begin
            state_q   <= ISSUE;
            side_q    <= grant_d;
            run_q     <= run_d;
            fifo_wr_q <= 1'b1;
            ack_hcp_q <= (grant_d == SIDE_HCP);
            ack_net_q <= (grant_d == SIDE_NET);
            // Counters step on the grant edge so the new count is visible
            // together with the ack during the ISSUE cycle.
            if (grant_d == SIDE_HCP) begin
              wdata_q   <= {iv_tsntag_hcp[47:34], iv_bufid_hcp};
              hcp_cnt_q <= hcp_cnt_q + 16'd1;
            end else begin
              wdata_q   <= {iv_tsntag_network[47:34], iv_bufid_network};
              net_cnt_q <= net_cnt_q + 16'd1;
            end
          end
        end
        ISSUE: begin
          state_q   <= IDLE;
          fifo_wr_q <= 1'b0;
          ack_hcp_q <= 1'b0;
          ack_net_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_fifo_wr                = fifo_wr_q;
  assign o_descriptor_ack_hcp     = ack_hcp_q;
  assign o_descriptor_ack_network = ack_net_q;
  assign ov_fifo_wdata            = wdata_q;
  assign ov_hcp_grant_cnt         = hcp_cnt_q;
  assign ov_net_grant_cnt         = net_cnt_q;

endmodule
